raster_bary_stream: RTL and testbench
=====================================

Name: raster_bary_stream

Overview:
Parametrised barycentric weight stage for the raster pipeline. It takes a pixel position, three edge values and the triangle area, and produces normalised weights w1..w3 = e/area in unsigned fixed point. A configurable number of per-vertex attribute channels is carried alongside the weights. Unlike the previous free-running stage it has a valid/ready handshake with full-pipeline stall, signed-area (winding) handling, clamping, degenerate-triangle flagging and a configurable divider radix.

Parameters:
FIXPT_W, 32, fixed-point word width of area/edges/weights
FRAC_BITS, 16, fraction bits; ONE = 1<<FRAC_BITS
NUM_ATTR, 3, attribute channels per vertex
ATTR_W, 8, bits per attribute channel
DIV_BPS, 1, quotient bits resolved per divider stage (1, 2 or 4; must divide FIXPT_W)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  input pixel valid
o_ready  out  1  stage accepts input this cycle
i_x, i_y  in  16 each  signed pixel coordinates
i_area  in  FIXPT_W  signed triangle doubled area
i_e1, i_e2, i_e3  in  FIXPT_W each  signed edge functions
i_attr_v1, i_attr_v2, i_attr_v3  in  NUM_ATTR*ATTR_W each  packed vertex attributes, channel 0 in LSBs
o_valid  out  1  output pixel valid
i_ready  in  1  downstream accepts output
o_x, o_y  out  16 each  pixel coordinates
o_w1, o_w2, o_w3  out  FIXPT_W each  unsigned weights, range 0..ONE
o_attr_v1, o_attr_v2, o_attr_v3  out  NUM_ATTR*ATTR_W each  attributes, delayed
o_degenerate  out  1  area was zero for this pixel
o_busy  out  1  at least one valid pixel held in the stage

Behaviour:
- Reset (async assert, sync release): all pipeline valid bits clear; o_valid=0, o_busy=0, o_degenerate=0; all output data 0. o_ready=1 after reset.
- Global advance: adv = !o_valid | i_ready. o_ready = adv (combinational). Every stage, including the divider, shifts only when adv=1; otherwise it holds. Input is accepted when i_valid & o_ready.
- Latency: LAT = FIXPT_W/DIV_BPS + 2 advancing cycles (input register, divider stages, output register). Default LAT = 34. Throughput is 1 pixel/cycle when i_ready=1.
- Input register: sa = sign(area). The operands are |area| and e' = sa ? -e : e. If e' < 0, the weight is forced to 0 (edge rounding). Degenerate = (area == 0).
- Divide: q = (e' << FRAC_BITS) / |area|, unsigned, truncating. The dividend is padded to 2*FIXPT_W bits with no overflow.
- Clamp: if q > ONE then w = ONE. If degenerate, all w = 0 and o_degenerate = 1.
- Bubbles: valid bits travel with the data. Data in invalid slots is don't-care but must never raise o_valid.
- Output stability: while o_valid=1 and i_ready=0, every output holds unchanged.
- o_busy = OR of all stage valid bits, including the output register.
- Reset mid-stream: all in-flight pixels are discarded, and no stale pixel appears after release.
- Coordinates and attributes are delay-matched by a shift register with the same advance.

Decomposition:
- Shared package/include (fixedpt): FIXPT_W, FRAC_BITS, the ONE constant, and the fixed-point width macro.
- Sub-module div_pipe_uu: an unsigned pipelined restoring divider.
  - Parameters: WIDTH, BPS.
  - Ports: i_clk, i_rst_n, i_en, z, d, q.
  - Stage count WIDTH/BPS. It has no valid logic of its own; validity is tracked in the parent.
  - Three instances, one per weight.
- A small generic delay-line sub-module for the sideband (x, y, attributes, flags) is optional.

Test Plan:
1. Basic divide: area=0x00040000, e1=0x00010000, e2=0x00010000, e3=0x00020000, i_ready=1 -> after 34 cycles o_valid=1, w=0x4000, 0x4000, 0x8000, x/y/attrs match the input.
2. Negative winding: area=0xFFFC0000 (-4.0), e=-1.0, -1.0, -2.0 -> w=0x4000, 0x4000, 0x8000. Separately, e1=+0x100 with negative area -> w1=0.
3. Degenerate and clamp:
   - area=0 -> w all 0, o_degenerate=1.
   - area=0x10000, e1=0x18000 -> w1=0x10000, o_degenerate=0.
4. Backpressure: stream 10 pixels with x=0..9 back-to-back and hold i_ready=0 for 5 cycles mid-flight -> all 10 emerge in order with no loss or duplication, outputs stay stable while stalled, and o_ready=0 exactly while o_valid & !i_ready.
5. Reset mid-operation: 6 pixels in flight, then pulse i_rst_n low for 1 cycle -> o_valid=0 and o_busy=0 immediately, and no output appears for 40 cycles after release with i_valid=0.
6. Radix sweep: repeat scenario 1 with DIV_BPS=2 and 4 -> identical weights at latency 18 and 10 respectively.

Source files
------------

// File: rtl/raster_bary_stream_pkg.sv
// rtl/raster_bary_stream_pkg.sv - fixed-point widths and defaults for the barycentric stage
`ifndef RBS_FIXPT_W
`define RBS_FIXPT_W 32
`endif

package raster_bary_stream_pkg;
   localparam int FIXPT_W   = `RBS_FIXPT_W;
   localparam int FRAC_BITS = 16;
   localparam int NUM_ATTR  = 3;
   localparam int ATTR_W    = 8;
   localparam int DIV_BPS   = 1;
   localparam int COORD_W   = 16;
   localparam logic [FIXPT_W-1:0] ONE = FIXPT_W'(1) << FRAC_BITS;
endpackage

// File: rtl/raster_bary_stream_div.sv
// rtl/raster_bary_stream_div.sv - unsigned pipelined restoring divider, BPS quotient bits per stage
module div_pipe_uu #(
   parameter int WIDTH = 32,
   parameter int BPS   = 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic [2*WIDTH-1:0] z,
   input  logic [WIDTH-1:0]   d,
   output logic [WIDTH-1:0]   q
);
   localparam int STAGES = WIDTH / BPS;

   // Upper half of p is the running remainder, lower half shifts dividend out and quotient in.
   // Callers guarantee z[2*WIDTH-1:WIDTH] < d so the quotient fits in WIDTH bits.
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic [2*WIDTH-1:0] p_in, p_d, p_q;
      logic [WIDTH-1:0]   d_in, d_q;

      if (s == 0) begin : g_first
         assign p_in = z;
         assign d_in = d;
      end else begin : g_next
         assign p_in = g_stage[s-1].p_q;
         assign d_in = g_stage[s-1].d_q;
      end

      always_comb begin
         logic [2*WIDTH:0] t;
         t   = '0;
         p_d = p_in;
         for (int b = 0; b < BPS; b++) begin
            t = {p_d, 1'b0};
            if (t[2*WIDTH:WIDTH] >= {1'b0, d_in}) begin
               t[2*WIDTH:WIDTH] = t[2*WIDTH:WIDTH] - {1'b0, d_in};
               t[0]             = 1'b1;
            end
            p_d = t[2*WIDTH-1:0];
         end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            p_q <= '0;
            d_q <= '0;
         end else if (i_en) begin
            p_q <= p_d;
            d_q <= d_in;
         end
      end
   end

   assign q = g_stage[STAGES-1].p_q[WIDTH-1:0];
endmodule

// File: rtl/raster_bary_stream.sv
// rtl/raster_bary_stream.sv - barycentric weight stage with valid/ready and whole-pipe stall
module raster_bary_stream #(
   parameter int FIXPT_W   = raster_bary_stream_pkg::FIXPT_W,
   parameter int FRAC_BITS = raster_bary_stream_pkg::FRAC_BITS,
   parameter int NUM_ATTR  = raster_bary_stream_pkg::NUM_ATTR,
   parameter int ATTR_W    = raster_bary_stream_pkg::ATTR_W,
   parameter int DIV_BPS   = raster_bary_stream_pkg::DIV_BPS
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [15:0]                i_x,
   input  logic [15:0]                i_y,
   input  logic [FIXPT_W-1:0]         i_area,
   input  logic [FIXPT_W-1:0]         i_e1,
   input  logic [FIXPT_W-1:0]         i_e2,
   input  logic [FIXPT_W-1:0]         i_e3,
   input  logic [NUM_ATTR*ATTR_W-1:0] i_attr_v1,
   input  logic [NUM_ATTR*ATTR_W-1:0] i_attr_v2,
   input  logic [NUM_ATTR*ATTR_W-1:0] i_attr_v3,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [15:0]                o_x,
   output logic [15:0]                o_y,
   output logic [FIXPT_W-1:0]         o_w1,
   output logic [FIXPT_W-1:0]         o_w2,
   output logic [FIXPT_W-1:0]         o_w3,
   output logic [NUM_ATTR*ATTR_W-1:0] o_attr_v1,
   output logic [NUM_ATTR*ATTR_W-1:0] o_attr_v2,
   output logic [NUM_ATTR*ATTR_W-1:0] o_attr_v3,
   output logic                       o_degenerate,
   output logic                       o_busy
);
   import raster_bary_stream_pkg::*;

   localparam int AW     = NUM_ATTR * ATTR_W;
   localparam int STAGES = FIXPT_W / DIV_BPS;
   localparam int SB_W   = 2*COORD_W + 3*AW + 7;
   localparam logic [FIXPT_W-1:0] W_ONE = FIXPT_W'(1) << FRAC_BITS;

   logic adv;
   assign adv     = !o_valid || i_ready;
   assign o_ready = adv;

   // Winding fold: a negative area flips every edge so the divide is always unsigned.
   // Negative edges force 0; e' >= |area| forces ONE, which also keeps the divider in range.
   logic               sa, degen;
   logic [FIXPT_W-1:0] abs_a;
   logic [FIXPT_W-1:0] ep  [3];
   logic [FIXPT_W-1:0] z_e [3];
   logic [2:0]         zero_f, one_f;

   always_comb begin
      sa     = i_area[FIXPT_W-1];
      abs_a  = sa ? -i_area : i_area;
      degen  = (i_area == '0);
      ep[0]  = sa ? -i_e1 : i_e1;
      ep[1]  = sa ? -i_e2 : i_e2;
      ep[2]  = sa ? -i_e3 : i_e3;
      zero_f = '0;
      one_f  = '0;
      for (int k = 0; k < 3; k++) begin
         z_e[k]    = '0;
         zero_f[k] = ep[k][FIXPT_W-1];
         one_f[k]  = !zero_f[k] && (ep[k] >= abs_a);
         if (!zero_f[k] && !one_f[k]) z_e[k] = ep[k];
      end
   end

   logic               in_v_q;
   logic [FIXPT_W-1:0] in_abs_q;
   logic [FIXPT_W-1:0] in_z_q [3];
   logic [SB_W-1:0]    in_sb_q, in_sb_d;

   assign in_sb_d = {i_x, i_y, i_attr_v1, i_attr_v2, i_attr_v3, degen, one_f, zero_f};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         in_v_q   <= 1'b0;
         in_abs_q <= '0;
         in_sb_q  <= '0;
         for (int k = 0; k < 3; k++) in_z_q[k] <= '0;
      end else if (adv) begin
         in_v_q   <= i_valid;
         in_abs_q <= abs_a;
         in_sb_q  <= in_sb_d;
         for (int k = 0; k < 3; k++) in_z_q[k] <= z_e[k];
      end
   end

   logic [FIXPT_W-1:0] q_w [3];
   for (genvar k = 0; k < 3; k++) begin : g_div
      logic [2*FIXPT_W-1:0] z_w;
      assign z_w = {{FIXPT_W{1'b0}}, in_z_q[k]} << FRAC_BITS;
      div_pipe_uu #(.WIDTH(FIXPT_W), .BPS(DIV_BPS)) u_div (
         .i_clk  (i_clk),
         .i_rst_n(i_rst_n),
         .i_en   (adv),
         .z      (z_w),
         .d      (in_abs_q),
         .q      (q_w[k])
      );
   end

   logic [SB_W-1:0]   sb_dly_q [STAGES];
   logic [STAGES-1:0] v_dly_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v_dly_q <= '0;
         for (int s = 0; s < STAGES; s++) sb_dly_q[s] <= '0;
      end else if (adv) begin
         v_dly_q     <= {v_dly_q[STAGES-2:0], in_v_q};
         sb_dly_q[0] <= in_sb_q;
         for (int s = 1; s < STAGES; s++) sb_dly_q[s] <= sb_dly_q[s-1];
      end
   end

   function automatic logic [FIXPT_W-1:0] sel_w(input logic dg, input logic zf, input logic of,
                                                input logic [FIXPT_W-1:0] q);
      if (dg || zf) return '0;
      else if (of)  return W_ONE;
      else          return q;
   endfunction

   logic [SB_W-1:0] sb_end;
   logic            end_dg;
   assign sb_end = sb_dly_q[STAGES-1];
   assign end_dg = sb_end[6];

   logic               out_v_q, out_dg_q;
   logic [15:0]        out_x_q, out_y_q;
   logic [FIXPT_W-1:0] out_w1_q, out_w2_q, out_w3_q;
   logic [AW-1:0]      out_a1_q, out_a2_q, out_a3_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         out_v_q  <= 1'b0;
         out_dg_q <= 1'b0;
         out_x_q  <= '0;
         out_y_q  <= '0;
         out_w1_q <= '0;
         out_w2_q <= '0;
         out_w3_q <= '0;
         out_a1_q <= '0;
         out_a2_q <= '0;
         out_a3_q <= '0;
      end else if (adv) begin
         out_v_q  <= v_dly_q[STAGES-1];
         out_dg_q <= end_dg;
         out_x_q  <= sb_end[7+3*AW+16 +: 16];
         out_y_q  <= sb_end[7+3*AW +: 16];
         out_a1_q <= sb_end[7+2*AW +: AW];
         out_a2_q <= sb_end[7+AW +: AW];
         out_a3_q <= sb_end[7 +: AW];
         out_w1_q <= sel_w(end_dg, sb_end[0], sb_end[3], q_w[0]);
         out_w2_q <= sel_w(end_dg, sb_end[1], sb_end[4], q_w[1]);
         out_w3_q <= sel_w(end_dg, sb_end[2], sb_end[5], q_w[2]);
      end
   end

   assign o_valid      = out_v_q;
   assign o_degenerate = out_dg_q;
   assign o_x          = out_x_q;
   assign o_y          = out_y_q;
   assign o_w1         = out_w1_q;
   assign o_w2         = out_w2_q;
   assign o_w3         = out_w3_q;
   assign o_attr_v1    = out_a1_q;
   assign o_attr_v2    = out_a2_q;
   assign o_attr_v3    = out_a3_q;
   assign o_busy       = in_v_q || (|v_dly_q) || out_v_q;
endmodule

// File: tb/tb_raster_bary_stream.sv
// tb/tb_raster_bary_stream.sv - directed vector bench for raster_bary_stream at radix 1, 2 and 4
module tb_raster_bary_stream;
   import raster_bary_stream_pkg::*;

   localparam int W  = 32;
   localparam int AW = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, i_valid, i_ready;
   logic [15:0]   i_x, i_y;
   logic [W-1:0]  i_area, i_e1, i_e2, i_e3;
   logic [AW-1:0] i_a1, i_a2, i_a3;

   logic          rdy [3], ov [3], dg [3], bsy [3];
   logic [15:0]   ox [3], oy [3];
   logic [W-1:0]  w1 [3], w2 [3], w3 [3];
   logic [AW-1:0] a1 [3], a2 [3], a3 [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      raster_bary_stream #(.FIXPT_W(32), .FRAC_BITS(16), .NUM_ATTR(3), .ATTR_W(8),
                           .DIV_BPS(1 << g)) u_dut (
         .i_clk       (clk),
         .i_rst_n     (rst_n),
         .i_valid     (i_valid),
         .o_ready     (rdy[g]),
         .i_x         (i_x),
         .i_y         (i_y),
         .i_area      (i_area),
         .i_e1        (i_e1),
         .i_e2        (i_e2),
         .i_e3        (i_e3),
         .i_attr_v1   (i_a1),
         .i_attr_v2   (i_a2),
         .i_attr_v3   (i_a3),
         .o_valid     (ov[g]),
         .i_ready     (i_ready),
         .o_x         (ox[g]),
         .o_y         (oy[g]),
         .o_w1        (w1[g]),
         .o_w2        (w2[g]),
         .o_w3        (w3[g]),
         .o_attr_v1   (a1[g]),
         .o_attr_v2   (a2[g]),
         .o_attr_v3   (a3[g]),
         .o_degenerate(dg[g]),
         .o_busy      (bsy[g])
      );
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [W-1:0] area, e1, e2, e3;
      logic [W-1:0] w1, w2, w3;
      logic         dg;
   } vec_t;

   vec_t vecs [7];
   int   exp_lat [3];

   initial begin
      vecs[0] = '{32'h00040000, 32'h00010000, 32'h00010000, 32'h00020000, 32'h4000, 32'h4000, 32'h8000, 1'b0};
      vecs[1] = '{32'hFFFC0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFE0000, 32'h4000, 32'h4000, 32'h8000, 1'b0};
      vecs[2] = '{32'hFFFC0000, 32'h00000100, 32'hFFFF0000, 32'hFFFE0000, 32'h0, 32'h4000, 32'h8000, 1'b0};
      vecs[3] = '{32'h00000000, 32'h00010000, 32'h00020000, 32'h00030000, 32'h0, 32'h0, 32'h0, 1'b1};
      vecs[4] = '{32'h00010000, 32'h00018000, 32'h00008000, 32'h00010000, ONE, 32'h8000, ONE, 1'b0};
      vecs[5] = '{32'h00030000, 32'h00010000, 32'h00020000, 32'h00000000, 32'h5555, 32'hAAAA, 32'h0, 1'b0};
      vecs[6] = '{32'h00000007, 32'h00000003, 32'h00000007, 32'hFFFFFFFF, 32'h6DB6, ONE, 32'h0, 1'b0};
      exp_lat = '{34, 18, 10};

      rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      i_x = '0; i_y = '0; i_area = '0; i_e1 = '0; i_e2 = '0; i_e3 = '0;
      i_a1 = '0; i_a2 = '0; i_a3 = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("reset.o_ready.d%0d", g), 64'(rdy[g]), 64'd1);
         chk($sformatf("reset.o_valid.d%0d", g), 64'(ov[g]), 64'd0);
         chk($sformatf("reset.o_busy.d%0d", g), 64'(bsy[g]), 64'd0);
         chk($sformatf("reset.o_degenerate.d%0d", g), 64'(dg[g]), 64'd0);
         chk($sformatf("reset.o_w1.d%0d", g), 64'(w1[g]), 64'd0);
      end

      // single pixels through all three radices
      for (int v = 0; v < 7; v++) begin
         int            lat [3];
         logic [15:0]   ex, ey;
         logic [AW-1:0] ea1, ea2, ea3;
         lat = '{0, 0, 0};
         ex  = 16'(v * 3 + 1);
         ey  = 16'hFF00 + 16'(v);
         ea1 = 24'h010203 + 24'(v);
         ea2 = 24'hA0B0C0 ^ 24'(v);
         ea3 = 24'(v * 7 + 5);
         i_valid = 1'b1; i_x = ex; i_y = ey; i_a1 = ea1; i_a2 = ea2; i_a3 = ea3;
         i_area = vecs[v].area; i_e1 = vecs[v].e1; i_e2 = vecs[v].e2; i_e3 = vecs[v].e3;
         for (int c = 1; c <= 60; c++) begin
            step();
            if (c == 1) begin
               i_valid = 1'b0; i_x = 16'hDEAD; i_y = 16'hBEEF;
               i_a1 = '1; i_a2 = '1; i_a3 = '1;
               i_area = 32'h12345; i_e1 = 32'h777; i_e2 = 32'h888; i_e3 = 32'h999;
            end
            for (int g = 0; g < 3; g++) begin
               if (ov[g] && lat[g] == 0) begin
                  lat[g] = c;
                  chk($sformatf("v%0d.w1.d%0d", v, g), 64'(w1[g]), 64'(vecs[v].w1));
                  chk($sformatf("v%0d.w2.d%0d", v, g), 64'(w2[g]), 64'(vecs[v].w2));
                  chk($sformatf("v%0d.w3.d%0d", v, g), 64'(w3[g]), 64'(vecs[v].w3));
                  chk($sformatf("v%0d.degen.d%0d", v, g), 64'(dg[g]), 64'(vecs[v].dg));
                  if (g == 0) begin
                     chk($sformatf("v%0d.x", v), 64'(ox[0]), 64'(ex));
                     chk($sformatf("v%0d.y", v), 64'(oy[0]), 64'(ey));
                     chk($sformatf("v%0d.attr1", v), 64'(a1[0]), 64'(ea1));
                     chk($sformatf("v%0d.attr2", v), 64'(a2[0]), 64'(ea2));
                     chk($sformatf("v%0d.attr3", v), 64'(a3[0]), 64'(ea3));
                  end
               end
            end
         end
         for (int g = 0; g < 3; g++)
            chk($sformatf("v%0d.latency.d%0d", v, g), 64'(lat[g]), 64'(exp_lat[g]));
      end

      // backpressure: 10 back-to-back pixels, 5-cycle stall while the stream drains
      begin
         int          nrecv;
         logic        stalled_prev;
         logic [15:0] px;
         logic [W-1:0] pw;
         nrecv = 0; stalled_prev = 1'b0; px = '0; pw = '0;
         i_area = vecs[0].area; i_e1 = vecs[0].e1; i_e2 = vecs[0].e2; i_e3 = vecs[0].e3;
         for (int it = 0; it < 80; it++) begin
            i_valid = (it < 10);
            i_x     = 16'(it);
            i_ready = !(it >= 36 && it < 41);
            #1;
            chk("bp.o_ready", 64'(rdy[0]), 64'(!(ov[0] && !i_ready)));
            if (stalled_prev) begin
               chk("bp.hold_valid", 64'(ov[0]), 64'd1);
               chk("bp.hold_x", 64'(ox[0]), 64'(px));
               chk("bp.hold_w1", 64'(w1[0]), 64'(pw));
            end
            if (ov[0] && i_ready) begin
               chk("bp.order", 64'(ox[0]), 64'(nrecv));
               chk("bp.w3", 64'(w3[0]), 64'h8000);
               nrecv++;
            end
            stalled_prev = ov[0] && !i_ready;
            px = ox[0];
            pw = w1[0];
            step();
         end
         chk("bp.count", 64'(nrecv), 64'd10);
         chk("bp.busy_after", 64'(bsy[0]), 64'd0);
      end

      // reset with pixels in flight and one held at the output
      begin
         int c, seen;
         i_ready = 1'b0;
         for (int k = 0; k < 6; k++) begin
            i_valid = 1'b1;
            i_x = 16'(100 + k);
            step();
         end
         i_valid = 1'b0;
         c = 0;
         while (!ov[0] && c < 60) begin
            step();
            c++;
         end
         chk("rst.pre_valid", 64'(ov[0]), 64'd1);
         chk("rst.pre_busy", 64'(bsy[0]), 64'd1);
         #1;
         rst_n = 1'b0;
         #1;
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst.o_valid.d%0d", g), 64'(ov[g]), 64'd0);
            chk($sformatf("rst.o_busy.d%0d", g), 64'(bsy[g]), 64'd0);
         end
         chk("rst.o_x", 64'(ox[0]), 64'd0);
         chk("rst.o_w3", 64'(w3[0]), 64'd0);
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         i_ready = 1'b1;
         seen = 0;
         for (int k = 0; k < 40; k++) begin
            step();
            for (int g = 0; g < 3; g++) if (ov[g] || bsy[g]) seen++;
         end
         chk("rst.no_stale", 64'(seen), 64'd0);
         chk("rst.o_ready_after", 64'(rdy[0]), 64'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
